// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare branch predictor: RISC-V control-flow opcodes,
// 2-bit counter encodings and the controller state codes.
package gshare_predictor_pkg;

    localparam logic [6:0] SB_ALL = 7'b1100011;
    localparam logic [6:0] UJ_JAL = 7'b1101111;
    localparam logic [6:0] I_JALR = 7'b1100111;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// Combinational 2-bit saturating counter step: moves one step toward taken or
// not-taken, sticking at strongly-not-taken and strongly-taken.
module gshare_predictor_sat_counter2
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] next
);

    always_comb begin
        next = cnt;
        case (cnt)
            CNT_SNT: next = inc ? CNT_WNT : CNT_SNT;
            CNT_WNT: next = inc ? CNT_WT  : CNT_SNT;
            CNT_WT:  next = inc ? CNT_ST  : CNT_WNT;
            default: next = inc ? CNT_ST  : CNT_WT;
        endcase
    end

endmodule

// File: rtl/gshare_predictor.sv
// Fetch-side gshare predictor: PHT of 2-bit counters indexed by PC^GHR plus a
// direct-mapped tagged BTB for JALR targets; one-cycle registered prediction.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int PHT_IDX_W = 9,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = 8,
    parameter int ADDR_W    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             q_ready,
    input  logic             q_valid,
    input  logic [31:0]      q_pc,
    input  logic [31:0]      q_inst,
    output logic             p_valid,
    output logic             p_taken,
    output logic [31:0]      p_target,
    output logic [GHR_W-1:0] p_ghr,
    input  logic             t_valid,
    input  logic [31:0]      t_pc,
    input  logic [GHR_W-1:0] t_ghr,
    input  logic             t_is_cond,
    input  logic             t_taken,
    input  logic [31:0]      t_target,
    input  logic             flush,
    input  logic [GHR_W-1:0] flush_ghr
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    // Handshake: a query is accepted on a rdy edge when q_valid && q_ready && !flush;
    // its prediction appears with p_valid=1 for exactly one rdy cycle afterwards.

    state_t               state;
    state_t               state_next;
    logic [PHT_IDX_W-1:0] init_cnt;
    logic [GHR_W-1:0]     ghr;

    logic [1:0]           pht       [PHT_N];
    logic [BTB_TAG_W-1:0] btb_tag   [BTB_N];
    logic [ADDR_W-1:0]    btb_data  [BTB_N];
    logic [BTB_N-1:0]     btb_valid;

    logic                 q_fire;
    logic                 t_fire;
    logic [PHT_IDX_W-1:0] pht_q_idx;
    logic [PHT_IDX_W-1:0] pht_t_idx;
    logic [BTB_IDX_W-1:0] btb_q_idx;
    logic [BTB_IDX_W-1:0] btb_t_idx;
    logic [BTB_TAG_W-1:0] btb_q_tag;
    logic [BTB_TAG_W-1:0] btb_t_tag;
    logic                 btb_hit;
    logic [31:0]          imm_b;
    logic [31:0]          imm_j;
    logic [31:0]          sum_b;
    logic [31:0]          sum_j;
    logic [31:0]          sum_4;
    logic                 pred_taken;
    logic [ADDR_W-1:0]    pred_target;
    logic [GHR_W-1:0]     ghr_q_next;
    logic [1:0]           cnt_next;
    logic                 pht_we;
    logic [PHT_IDX_W-1:0] pht_wa;
    logic [1:0]           pht_wd;
    logic                 btb_we;
    logic                 unused_ok;

    assign q_ready = (state == ST_RUN);
    assign q_fire  = q_ready && q_valid && !flush;
    assign t_fire  = q_ready && t_valid;

    assign pht_q_idx = q_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign pht_t_idx = t_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(t_ghr);
    assign btb_q_idx = q_pc[BTB_IDX_W+1:2];
    assign btb_t_idx = t_pc[BTB_IDX_W+1:2];
    assign btb_q_tag = q_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign btb_t_tag = t_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign btb_hit   = btb_valid[btb_q_idx] && (btb_tag[btb_q_idx] == btb_q_tag);

    assign imm_b = {{20{q_inst[31]}}, q_inst[7], q_inst[30:25], q_inst[11:8], 1'b0};
    assign imm_j = {{12{q_inst[31]}}, q_inst[19:12], q_inst[20], q_inst[30:21], 1'b0};
    assign sum_b = q_pc + imm_b;
    assign sum_j = q_pc + imm_j;
    assign sum_4 = q_pc + 32'd4;

    // Bits above ADDR_W and instruction fields the decoder does not look at.
    assign unused_ok = ^{q_pc, q_inst, t_pc, t_target, imm_b, imm_j, sum_b, sum_j, sum_4};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = sum_4[ADDR_W-1:0];
        ghr_q_next  = ghr;
        case (q_inst[6:0])
            SB_ALL: begin
                pred_taken  = pht[pht_q_idx][1];
                pred_target = pred_taken ? sum_b[ADDR_W-1:0] : sum_4[ADDR_W-1:0];
                ghr_q_next  = {ghr[GHR_W-2:0], pred_taken};
            end
            UJ_JAL: begin
                pred_taken  = 1'b1;
                pred_target = sum_j[ADDR_W-1:0];
            end
            I_JALR: begin
                if (btb_hit) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_data[btb_q_idx];
                end
            end
            default: ;
        endcase
    end

    gshare_predictor_sat_counter2 u_sat (
        .cnt  (pht[pht_t_idx]),
        .inc  (t_taken),
        .next (cnt_next)
    );

    // The INIT walk owns the single PHT write port until every entry is weak-NT.
    always_comb begin
        pht_we = 1'b0;
        pht_wa = pht_t_idx;
        pht_wd = cnt_next;
        if (rdy) begin
            if (state == ST_INIT) begin
                pht_we = 1'b1;
                pht_wa = init_cnt;
                pht_wd = CNT_WNT;
            end else if (t_fire && t_is_cond) begin
                pht_we = 1'b1;
            end
        end
    end

    assign btb_we = rdy && t_fire && t_taken;

    always_comb begin
        state_next = state;
        if (rdy && (state == ST_INIT) && (init_cnt == {PHT_IDX_W{1'b1}})) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            ghr       <= '0;
            btb_valid <= '0;
            p_valid   <= 1'b0;
            p_taken   <= 1'b0;
            p_target  <= '0;
            p_ghr     <= '0;
        end else if (rdy) begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (state == ST_RUN) begin
                if (flush) begin
                    ghr <= flush_ghr;
                end else if (q_fire) begin
                    ghr <= ghr_q_next;
                end
            end
            if (btb_we) begin
                btb_valid[btb_t_idx] <= 1'b1;
            end
            p_valid <= q_fire;
            if (q_fire) begin
                p_taken  <= pred_taken;
                p_target <= {{(32-ADDR_W){1'b0}}, pred_target};
                p_ghr    <= ghr;
            end
        end
    end

    // Tables have no reset; the PHT is cleared by the INIT walk, the BTB by its valid bits.
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_wa] <= pht_wd;
        end
        if (btb_we) begin
            btb_tag[btb_t_idx]  <= btb_t_tag;
            btb_data[btb_t_idx] <= t_target[ADDR_W-1:0];
        end
    end

endmodule
